// File: rtl/kmeans_sched_if.sv
// Handshake bundle between the k-means iteration scheduler and its datapath.
// The master side is the scheduler; the slave side is the datapath and control host.
interface kmeans_sched_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned K_W    = 4,
   parameter int unsigned ITER_W = 6
);
   logic              start;
   logic [ADDR_W-1:0] cfg_size;
   logic [K_W-1:0]    cfg_k;
   logic              clr_acc;
   logic              pt_req;
   logic [ADDR_W-1:0] pt_addr;
   logic              pt_ack;
   logic              upd_req;
   logic [K_W-1:0]    upd_idx;
   logic              upd_ack;
   logic              upd_moved;
   logic              busy;
   logic              done;
   logic              converged;
   logic [ITER_W-1:0] iter_count;

   modport master (
      input  start, cfg_size, cfg_k, pt_ack, upd_ack, upd_moved,
      output clr_acc, pt_req, pt_addr, upd_req, upd_idx, busy, done, converged, iter_count
   );

   modport slave (
      output start, cfg_size, cfg_k, pt_ack, upd_ack, upd_moved,
      input  clr_acc, pt_req, pt_addr, upd_req, upd_idx, busy, done, converged, iter_count
   );
endinterface

// File: rtl/kmeans_sched.sv
// K-means iteration scheduler: per iteration it clears accumulators, streams point
// addresses, walks every mean through update, and stops on convergence or the cap.
module kmeans_sched #(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned K_W      = 4,
   parameter int unsigned MAX_ITER = 32,
   parameter int unsigned ITER_W   = 6
) (
   input  logic             clk,
   input  logic             reset,
   kmeans_sched_if.master   bus_io
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StAssign,
      StUpdate,
      StCheck,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] size_q, size_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [K_W-1:0]    idx_q, idx_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              conv_q, conv_d;
   logic              moved_q, moved_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         size_q  <= '0;
         k_q     <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
         moved_q <= 1'b0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         k_q     <= k_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         iter_q  <= iter_d;
         conv_q  <= conv_d;
         moved_q <= moved_d;
      end
   end

   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      k_d     = k_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      iter_d  = iter_q;
      conv_d  = conv_q;
      moved_d = moved_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus_io.start) begin
               size_d = bus_io.cfg_size;
               k_d    = bus_io.cfg_k;
               iter_d = '0;
               conv_d = 1'b0;
               // An empty point set is trivially converged.
               if (bus_io.cfg_size == '0) begin
                  state_d = StDone;
                  conv_d  = 1'b1;
               end else begin
                  state_d = StClear;
               end
            end
         end
         StClear: begin
            moved_d = 1'b0;
            addr_d  = '0;
            state_d = StAssign;
         end
         StAssign: begin
            if (bus_io.pt_ack) begin
               if (addr_q == size_q - ADDR_W'(1)) begin
                  idx_d   = '0;
                  state_d = StUpdate;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         StUpdate: begin
            if (bus_io.upd_ack) begin
               moved_d = moved_q | bus_io.upd_moved;
               if (idx_q == k_q) begin
                  state_d = StCheck;
               end else begin
                  idx_d = idx_q + K_W'(1);
               end
            end
         end
         StCheck: begin
            iter_d = iter_q + ITER_W'(1);
            if (!moved_q) begin
               conv_d  = 1'b1;
               state_d = StDone;
            end else if (iter_d == ITER_W'(MAX_ITER)) begin
               conv_d  = 1'b0;
               state_d = StDone;
            end else begin
               state_d = StClear;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decode registered state only, so they move strictly on clock edges.
   assign bus_io.clr_acc    = (state_q == StClear);
   assign bus_io.pt_req     = (state_q == StAssign);
   assign bus_io.pt_addr    = addr_q;
   assign bus_io.upd_req    = (state_q == StUpdate);
   assign bus_io.upd_idx    = idx_q;
   assign bus_io.busy       = (state_q == StClear) || (state_q == StAssign) ||
                              (state_q == StUpdate) || (state_q == StCheck);
   assign bus_io.done       = (state_q == StDone);
   assign bus_io.converged  = conv_q;
   assign bus_io.iter_count = iter_q;

endmodule

// File: tb/tb_kmeans_sched.sv
// Randomized directed bench for kmeans_sched: a responder drives the datapath side
// and each run is scored against an iteration-level model of the schedule.
module tb_kmeans_sched;
   localparam int MaxIter = 3;

   logic clk;
   logic reset;
   int   total;
   int   passed;
   int   fails;

   kmeans_sched_if #(.ADDR_W(10), .K_W(4), .ITER_W(6)) bus ();

   kmeans_sched #(
      .ADDR_W  (10),
      .K_W     (4),
      .MAX_ITER(MaxIter),
      .ITER_W  (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus_io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] moved_tbl [1:MaxIter];
   int          pt_log[$];
   int          upd_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({bus.clr_acc, bus.pt_req, bus.pt_addr, bus.upd_req, bus.upd_idx,
                  bus.busy, bus.done, bus.converged, bus.iter_count});
   endfunction

   // moved_mode: 0 never, 1 always, 2 only mean 15 in iteration 1, 3 random
   task automatic run(input int n, input int k, input int pw_lo, input int pw_hi,
                      input int uw_lo, input int uw_hi, input int moved_mode,
                      input int mid_start, input bit rst_upd);
      int c, it, wsum, pw, uw, exp_i, exp_cyc;
      bit ppend, upend, got_done, exp_conv, any;
      logic [9:0]  phold;
      logic [3:0]  uhold;
      logic [15:0] mask;
      int exp_pt[$];
      int exp_upd[$];
      pt_log.delete();
      upd_log.delete();
      for (int i = 1; i <= MaxIter; i++) begin
         case (moved_mode)
            0:       moved_tbl[i] = 16'h0;
            1:       moved_tbl[i] = 16'hFFFF;
            2:       moved_tbl[i] = (i == 1) ? 16'h8000 : 16'h0;
            default: moved_tbl[i] = 16'($urandom & $urandom & $urandom);
         endcase
      end
      bus.start    = 1'b1;
      bus.cfg_size = 10'(n);
      bus.cfg_k    = 4'(k);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      c = 0; it = 0; wsum = 0; ppend = 0; upend = 0; got_done = 0;
      phold = '0; uhold = '0; pw = 0; uw = 0;
      if (n > 0) begin
         chk("busy_after_start", 32'(bus.busy), 1);
         chk("clr_after_start", 32'(bus.clr_acc), 1);
      end
      while (!got_done && c < 3000) begin
         if (bus.done) begin
            got_done = 1;
         end else begin
            if (bus.clr_acc) it++;
            if (bus.pt_req) begin
               if (!ppend) begin
                  ppend = 1;
                  pw    = $urandom_range(pw_hi, pw_lo);
                  wsum += pw;
                  phold = bus.pt_addr;
               end else begin
                  chk("pt_addr_stable", 32'(bus.pt_addr), 32'(phold));
               end
               if (pw == 0) begin
                  bus.pt_ack = 1'b1;
                  pt_log.push_back(int'(bus.pt_addr));
                  ppend = 0;
               end else begin
                  pw--;
                  bus.pt_ack = 1'b0;
               end
            end else begin
               bus.pt_ack = 1'($urandom);
            end
            if (bus.upd_req) begin
               if (!upend) begin
                  upend = 1;
                  uw    = $urandom_range(uw_hi, uw_lo);
                  wsum += uw;
                  uhold = bus.upd_idx;
               end else begin
                  chk("upd_idx_stable", 32'(bus.upd_idx), 32'(uhold));
               end
               if (uw == 0) begin
                  bus.upd_ack   = 1'b1;
                  bus.upd_moved = (it >= 1 && it <= MaxIter) ? moved_tbl[it][bus.upd_idx] : 1'b0;
                  upd_log.push_back(int'(bus.upd_idx));
                  upend = 0;
               end else begin
                  uw--;
                  bus.upd_ack   = 1'b0;
                  bus.upd_moved = 1'($urandom);
               end
               if (rst_upd) begin
                  reset = 1'b0;
                  @(posedge clk);
                  #1;
                  reset       = 1'b1;
                  bus.pt_ack  = 1'b0;
                  bus.upd_ack = 1'b0;
                  chk("outputs_after_mid_reset", out_vec(), 0);
                  return;
               end
            end else begin
               bus.upd_ack   = 1'($urandom);
               bus.upd_moved = 1'($urandom);
            end
            bus.start = (c == mid_start) && bus.pt_req;
            if (bus.start) begin
               bus.cfg_size = 10'(n + 3);
               bus.cfg_k    = 4'(k + 1);
            end else begin
               bus.cfg_size = 10'($urandom);
               bus.cfg_k    = 4'($urandom);
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            c++;
         end
      end
      if (!got_done) begin
         chk("done_timeout", 0, 1);
         return;
      end

      // Reference: iterate on the moved table with the convergence / cap rules.
      mask     = (k == 15) ? 16'hFFFF : 16'((32'd1 << (k + 1)) - 1);
      exp_i    = 0;
      exp_conv = 1;
      if (n > 0) begin
         for (int i = 1; i <= MaxIter; i++) begin
            any   = |(moved_tbl[i] & mask);
            exp_i = i;
            exp_conv = !any;
            if (!any) break;
         end
      end
      for (int i = 0; i < exp_i; i++) begin
         for (int a = 0; a < n; a++) exp_pt.push_back(a);
         for (int j = 0; j <= k; j++) exp_upd.push_back(j);
      end
      exp_cyc = exp_i * (n + k + 3) + wsum;

      chk("done_cycle", 32'(c), 32'(exp_cyc));
      chk("clr_pulses", 32'(it), 32'(exp_i));
      chk("iter_count", 32'(bus.iter_count), 32'(exp_i));
      chk("converged", 32'(bus.converged), 32'(exp_conv));
      chk("busy_at_done", 32'(bus.busy), 0);
      chk("pt_count", 32'(pt_log.size()), 32'(exp_pt.size()));
      for (int i = 0; i < exp_pt.size() && i < pt_log.size(); i++)
         chk("pt_seq", 32'(pt_log[i]), 32'(exp_pt[i]));
      chk("upd_count", 32'(upd_log.size()), 32'(exp_upd.size()));
      for (int i = 0; i < exp_upd.size() && i < upd_log.size(); i++)
         chk("upd_seq", 32'(upd_log[i]), 32'(exp_upd[i]));
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("done_held", 32'(bus.done), 1);
      chk("iter_held", 32'(bus.iter_count), 32'(exp_i));
   endtask

   initial begin
      total = 0; passed = 0; fails = 0;
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.cfg_size  = '0;
      bus.cfg_k     = '0;
      bus.pt_ack    = 1'b0;
      bus.upd_ack   = 1'b0;
      bus.upd_moved = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", out_vec(), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_outputs", out_vec(), 0);

      run(4, 1, 0, 0, 0, 0, 0, -1, 0);
      run(3, 0, 0, 0, 0, 0, 1, -1, 0);
      run(5, 2, 2, 2, 0, 3, 3, -1, 0);
      run(5, 1, 0, 2, 0, 1, 0, 3, 0);
      run(0, 4, 0, 0, 0, 0, 0, -1, 0);
      run(6, 3, 0, 1, 0, 2, 1, -1, 1);
      run(4, 2, 0, 1, 0, 1, 3, -1, 0);
      run(1, 15, 0, 0, 0, 0, 2, -1, 0);
      for (int r = 0; r < 6; r++)
         run($urandom_range(12, 1), $urandom_range(15, 0), 0, $urandom_range(2, 0),
             0, $urandom_range(2, 0), 3, -1, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
